// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port fixed-priority arbiter with starvation guard in front of a 1-cycle SRAM macro
// m0 wins by default; m1 is forced through after STARVE_LIMIT consecutive m0 grants.
module sram_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 9,
  parameter int NUM_WMASKS   = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [NUM_WMASKS-1:0] m0_wmask,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [NUM_WMASKS-1:0] m1_wmask,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  sram_csb,
  output logic                  sram_web,
  output logic [NUM_WMASKS-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_din,
  input  logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  busy
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt;
  logic       m1_win;
  logic       any_gnt;
  logic       sel_we;
  logic       rd0_s1;
  logic       rd1_s1;
  logic       s2_valid;

  assign m1_win  = m1_req && (!m0_req || starve_cnt == LIMIT);
  assign m1_gnt  = !rst && m1_win;
  assign m0_gnt  = !rst && m0_req && !m1_win;
  assign any_gnt = m0_gnt || m1_gnt;
  assign sel_we  = m1_win ? m1_we : m0_we;

  assign rdata = sram_dout;
  assign busy  = !sram_csb || s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
      sram_csb   <= 1'b1;
      sram_web   <= 1'b1;
      sram_wmask <= '0;
      sram_addr  <= '0;
      sram_din   <= '0;
      rd0_s1     <= 1'b0;
      rd1_s1     <= 1'b0;
      s2_valid   <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
    end else begin
      if (m1_gnt || !m1_req)
        starve_cnt <= '0;
      else if (m0_gnt && starve_cnt != LIMIT)
        starve_cnt <= starve_cnt + 4'd1;

      // Stage 1: the granted command drives the macro directly from these registers.
      if (any_gnt) begin
        sram_csb   <= 1'b0;
        sram_web   <= !sel_we;
        sram_wmask <= sel_we ? (m1_win ? m1_wmask : m0_wmask) : '0;
        sram_addr  <= m1_win ? m1_addr : m0_addr;
        sram_din   <= m1_win ? m1_wdata : m0_wdata;
      end else begin
        sram_csb   <= 1'b1;
        sram_web   <= 1'b1;
        sram_wmask <= '0;
      end
      rd0_s1 <= m0_gnt && !m0_we;
      rd1_s1 <= m1_gnt && !m1_we;

      // Stage 2: macro output is valid now, so flag the owning port.
      s2_valid  <= !sram_csb;
      m0_rvalid <= rd0_s1;
      m1_rvalid <= rd1_s1;
    end
  end

endmodule

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
  DATA_WIDTH, 32, data word width.
  ADDR_WIDTH, 9, word address width.
  NUM_WMASKS, 4, byte write-enable count (DATA_WIDTH/8).
  STARVE_LIMIT, 4, max consecutive m0 grants while m1 waits; legal range 1..15.
REQ-002 Ports SHALL be, one per line as name, direction, width, meaning:
  clk  in  1  sole clock; all state on rising edge.
  rst  in  1  asynchronous active-high reset.
  m0_req / m1_req  in  1  requester command valid.
  m0_we / m1_we  in  1  1=write, 0=read.
  m0_wmask / m1_wmask  in  NUM_WMASKS  byte enables, active high, writes only.
  m0_addr / m1_addr  in  ADDR_WIDTH  word address.
  m0_wdata / m1_wdata  in  DATA_WIDTH  write data.
  m0_gnt / m1_gnt  out  1  command accepted this cycle.
  m0_rvalid / m1_rvalid  out  1  one-cycle read-data-valid pulse.
  rdata  out  DATA_WIDTH  shared read data, meaningful only with an rvalid.
  sram_csb  out  1  macro chip select, active low.
  sram_web  out  1  macro write enable, active low.
  sram_wmask  out  NUM_WMASKS  macro byte mask, active high.
  sram_addr  out  ADDR_WIDTH  macro address.
  sram_din  out  DATA_WIDTH  macro write data.
  sram_dout  in  DATA_WIDTH  macro read data, valid the cycle after the macro samples.
  busy  out  1  any command in the pipeline.
REQ-003 Clock and reset SHALL be exactly the single clock clk and asynchronous active-high reset rst.

Function
REQ-004 A transfer SHALL occur in cycle T when mX_req and mX_gnt are both 1; mX_gnt SHALL be combinational from current-cycle req and registered arbiter state.
REQ-005 Requesters SHALL hold req and command fields stable until gnt; withdrawing req before gnt SHALL be legal and create no transfer.
REQ-006 At most one gnt SHALL be asserted per cycle; gnt SHALL never assert without its req.
REQ-007 Default priority SHALL be m0; m1 SHALL win when m0_req=0, or when starve_cnt equals STARVE_LIMIT and m1_req=1.
REQ-008 starve_cnt SHALL increment on each m0 grant while m1_req=1, clear on any m1 grant or any cycle with m1_req=0, and saturate at STARVE_LIMIT.
REQ-009 The granted command SHALL be registered at the end of cycle T and driven to the macro in cycle T+1: sram_csb=0, sram_web=~we, sram_addr, sram_din=wdata, sram_wmask=wmask for writes and all-zero for reads.
REQ-010 In any cycle with no registered command, sram_csb SHALL be 1, sram_web 1, sram_wmask 0; addr/din SHALL hold previous values.
REQ-011 A granted read SHALL produce exactly one rvalid pulse on the granting port in cycle T+2; rdata SHALL be sram_dout passed through combinationally.
REQ-012 Writes SHALL produce no rvalid; a write with all-zero wmask SHALL still be granted and issued, modifying no bytes.
REQ-013 Throughput SHALL be one command per cycle with no bubbles; back-to-back commands from either port SHALL pipeline, and rvalid pulses SHALL return in grant order.
REQ-014 A read to the address of a write granted in an earlier cycle SHALL return the written data.
REQ-015 busy SHALL be 1 while any command sits in the T+1 or T+2 pipeline stages.

Reset
REQ-016 While rst=1: all gnt=0, all rvalid=0, busy=0, sram_csb=1, sram_web=1, sram_wmask=0, sram_addr=0, sram_din=0, starve_cnt=0.
REQ-017 Reset asserted mid-operation SHALL discard all in-flight commands; no rvalid SHALL emerge after rst deasserts for commands granted before it.
REQ-018 The first grant SHALL be possible in the first cycle with rst=0.

Verification
REQ-019 Benches SHALL cover these directed scenarios:
  m0 write addr 0x005, data 0xDEADBEEF, wmask 0xF; next cycle m0 read 0x005 -> m0_rvalid two cycles after read grant, rdata=0xDEADBEEF.
  Write 0x11223344 to 0x1FF, then wmask 0x2 write 0x0000AA00 -> read 0x1FF returns 0x1122AA44.
  m0 and m1 requesting continuously, STARVE_LIMIT=4 -> grant sequence m0,m0,m0,m0,m1 repeating; no m1 wait exceeds 4 cycles.
  m0 idle, m1 reads 0x000..0x003 back-to-back -> four consecutive m1_gnt, four consecutive m1_rvalid starting two cycles after first grant.
  rst pulsed one cycle after a read grant -> sram_csb=1 immediately, no rvalid afterwards, busy=0.
  Idle for 10 cycles -> sram_csb=1 throughout, no gnt, no rvalid.
